// File: rtl/div_pkg.sv
// Shared types and saturation helpers for the divider arbiter.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } div_state_e;

  // Largest positive quotient for a w-bit signed result.
  function automatic int unsigned sat_max(input int unsigned w);
    return (32'd1 << (w - 1)) - 32'd1;
  endfunction

  // Most negative quotient (bit pattern 100..0) for a w-bit signed result.
  function automatic int unsigned sat_min(input int unsigned w);
    return 32'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the search starts one past the last accepted requester.
module rr_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               accept,
  output logic [NUM_REQ-1:0] grant
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PW-1:0] ptr_reg;
  logic [PW-1:0] win_idx;
  logic [PW-1:0] cand;
  logic          found;

  always_comb begin
    grant   = '0;
    found   = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = PW'((int'(ptr_reg) + i) % NUM_REQ);
      if (!found && req[cand]) begin
        found   = 1'b1;
        win_idx = cand;
      end
    end
    if (found) grant[win_idx] = 1'b1;
  end

  // Pointer parks on the last requester so requester 0 wins first out of reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_reg <= PW'(NUM_REQ - 1);
    end else if (accept && found) begin
      ptr_reg <= win_idx;
    end
  end

endmodule

// File: rtl/div_arbiter.sv
// Shares one fixed-point divider among several requesters, one operation at a time,
// with divide-by-zero bypass, stale-result filtering and a timeout abort.
module div_arbiter
  import div_pkg::*;
#(
  parameter int IN_WIDTH  = 12,
  parameter int OUT_WIDTH = 12,
  parameter int NUM_REQ   = 2,
  parameter int LATENCY   = 2 * IN_WIDTH,
  parameter int TIMEOUT   = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ*IN_WIDTH-1:0] req_rs1,
  input  logic [NUM_REQ*IN_WIDTH-1:0] req_rs2,
  output logic [NUM_REQ-1:0]          resp_valid,
  input  logic [NUM_REQ-1:0]          resp_ready,
  output logic [OUT_WIDTH-1:0]        resp_rd,
  output logic                        resp_err,
  output logic [IN_WIDTH-1:0]         div_rs1,
  output logic [IN_WIDTH-1:0]         div_rs2,
  input  logic [OUT_WIDTH-1:0]        div_rd,
  input  logic                        div_valid
);

  localparam int CNT_MAX = LATENCY + TIMEOUT;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [OUT_WIDTH-1:0] RD_POS = OUT_WIDTH'(sat_max(OUT_WIDTH));
  localparam logic [OUT_WIDTH-1:0] RD_NEG = OUT_WIDTH'(sat_min(OUT_WIDTH));

  div_state_e           state_reg, state_next;
  logic [CW-1:0]        cnt_reg, cnt_next;
  logic [NUM_REQ-1:0]   owner_reg, owner_next;
  logic [NUM_REQ-1:0]   req_ready_reg, req_ready_next;
  logic [OUT_WIDTH-1:0] rd_reg, rd_next;
  logic                 err_reg, err_next;
  logic [IN_WIDTH-1:0]  div_rs1_reg, div_rs1_next;
  logic [IN_WIDTH-1:0]  div_rs2_reg, div_rs2_next;

  logic [NUM_REQ-1:0]   arb_req;
  logic [NUM_REQ-1:0]   grant;
  logic                 accept;
  logic [IN_WIDTH-1:0]  rs1_masked [NUM_REQ];
  logic [IN_WIDTH-1:0]  rs2_masked [NUM_REQ];
  logic [IN_WIDTH-1:0]  sel_rs1, sel_rs2;

  assign arb_req = (state_reg == IDLE) ? req_valid : '0;

  rr_arbiter #(
    .NUM_REQ(NUM_REQ)
  ) u_rr_arbiter (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (arb_req),
    .accept(accept),
    .grant (grant)
  );

  // One-hot operand select: mask each lane by its grant bit, then OR.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_mask
    assign rs1_masked[gi] = grant[gi] ? req_rs1[gi*IN_WIDTH +: IN_WIDTH] : '0;
    assign rs2_masked[gi] = grant[gi] ? req_rs2[gi*IN_WIDTH +: IN_WIDTH] : '0;
  end

  always_comb begin
    sel_rs1 = '0;
    sel_rs2 = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sel_rs1 |= rs1_masked[i];
      sel_rs2 |= rs2_masked[i];
    end
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    owner_next     = owner_reg;
    req_ready_next = '0;
    rd_next        = rd_reg;
    err_next       = err_reg;
    div_rs1_next   = div_rs1_reg;
    div_rs2_next   = div_rs2_reg;
    accept         = 1'b0;
    case (state_reg)
      IDLE: begin
        if (|grant) begin
          accept         = 1'b1;
          req_ready_next = grant;
          owner_next     = grant;
          if (sel_rs2 == '0) begin
            state_next = RESP;
            err_next   = 1'b1;
            rd_next    = sel_rs1[IN_WIDTH-1] ? RD_NEG : RD_POS;
          end else begin
            state_next   = WAIT;
            cnt_next     = '0;
            div_rs1_next = sel_rs1;
            div_rs2_next = sel_rs2;
          end
        end
      end
      WAIT: begin
        if (cnt_reg != CW'(CNT_MAX)) cnt_next = cnt_reg + CW'(1);
        if (div_valid && (cnt_reg >= CW'(LATENCY))) begin
          state_next = RESP;
          rd_next    = div_rd;
          err_next   = 1'b0;
        end else if (cnt_reg >= CW'(CNT_MAX - 1)) begin
          // Counter reaches LATENCY+TIMEOUT on this edge: abort.
          state_next = RESP;
          rd_next    = '0;
          err_next   = 1'b1;
        end
      end
      RESP: begin
        if ((resp_ready & owner_reg) != '0) begin
          state_next   = IDLE;
          div_rs1_next = '0;
          div_rs2_next = '0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      owner_reg     <= '0;
      req_ready_reg <= '0;
      rd_reg        <= '0;
      err_reg       <= 1'b0;
      div_rs1_reg   <= '0;
      div_rs2_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      owner_reg     <= owner_next;
      req_ready_reg <= req_ready_next;
      rd_reg        <= rd_next;
      err_reg       <= err_next;
      div_rs1_reg   <= div_rs1_next;
      div_rs2_reg   <= div_rs2_next;
    end
  end

  assign req_ready  = req_ready_reg;
  assign resp_valid = (state_reg == RESP) ? owner_reg : '0;
  assign resp_rd    = rd_reg;
  assign resp_err   = err_reg;
  assign div_rs1    = div_rs1_reg;
  assign div_rs2    = div_rs2_reg;

endmodule

// File: tb/tb_div_arbiter.sv
// Directed bench for div_arbiter with a behavioural Q1.11 divider stub.
module tb_div_arbiter;

  localparam int W   = 12;
  localparam int LAT = 24;
  localparam int TO  = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    req_valid;
  logic [1:0]    req_ready;
  logic [2*W-1:0] req_rs1, req_rs2;
  logic [1:0]    resp_valid;
  logic [1:0]    resp_ready;
  logic [W-1:0]  resp_rd;
  logic          resp_err;
  logic [W-1:0]  div_rs1, div_rs2, div_rd;
  logic          div_valid;
  logic          stub_dead;
  int            tb_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  div_arbiter #(
    .IN_WIDTH(W), .OUT_WIDTH(W), .NUM_REQ(2), .LATENCY(LAT), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_rs1(req_rs1), .req_rs2(req_rs2),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rd(resp_rd), .resp_err(resp_err),
    .div_rs1(div_rs1), .div_rs2(div_rs2),
    .div_rd(div_rd), .div_valid(div_valid)
  );

  // Divider stub: Q1.11 quotient, valid a few cycles after operands appear
  // (well before LATENCY, so early results must be ignored by the DUT).
  function automatic logic [W-1:0] div_model(input logic [W-1:0] a, input logic [W-1:0] b);
    int sa;
    int sb;
    int q;
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (sb == 0) return '0;
    q = (sa * 2048) / sb;
    if (q > 2047) q = 2047;
    if (q < -2048) q = -2048;
    return W'(q);
  endfunction

  always @(posedge clk) begin
    if (div_rs2 == '0) tb_cnt <= 0;
    else if (tb_cnt < 1000) tb_cnt <= tb_cnt + 1;
  end

  assign div_rd    = div_model(div_rs1, div_rs2);
  assign div_valid = !stub_dead && (tb_cnt >= 4);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Raise req_valid on one requester and wait for its accept pulse.
  task automatic issue(input int idx, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [1:0] rdy, output logic ok);
    ok = 1'b0;
    rdy = '0;
    req_rs1[idx*W +: W] = a;
    req_rs2[idx*W +: W] = b;
    req_valid[idx] = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      tick();
      if (req_ready != '0) begin
        ok = 1'b1;
        rdy = req_ready;
      end
    end
    req_valid[idx] = 1'b0;
  endtask

  // Cycles from the accept cycle until resp_valid rises.
  task automatic wait_resp(output int cyc, output logic ok);
    ok = 1'b0;
    cyc = 0;
    while (!ok && cyc < 100) begin
      tick();
      cyc++;
      if (resp_valid != '0) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = '0; resp_ready = '0; req_rs1 = '0; req_rs2 = '0; stub_dead = 1'b0;
    tick(); tick(); tick();
    total++;
    if ({req_ready, resp_valid, resp_rd, resp_err, div_rs1, div_rs2} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got rdy=%b vld=%b rd=%0d err=%b rs1=%0d rs2=%0d want all 0",
               req_ready, resp_valid, resp_rd, resp_err, div_rs1, div_rs2);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_seq [4];
    logic ok;
    int cyc;
    exp_seq[0] = 2'b01; exp_seq[1] = 2'b10; exp_seq[2] = 2'b01; exp_seq[3] = 2'b10;
    req_rs1 = {12'd7, 12'd9};
    req_rs2 = '0;
    req_valid = 2'b11;
    for (int n = 0; n < 4; n++) begin
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
        tick();
        if (req_ready != '0) ok = 1'b1;
      end
      total++;
      if (!ok || req_ready !== exp_seq[n]) begin
        bad++;
        $display("FAIL rr_grant%0d: got %b want %b", n, req_ready, exp_seq[n]);
      end
      wait_resp(cyc, ok);
      total++;
      if (!ok || resp_valid !== exp_seq[n]) begin
        bad++;
        $display("FAIL rr_resp%0d: got %b want %b", n, resp_valid, exp_seq[n]);
      end
      $display("rr op %0d: grant=%b resp_valid=%b", n, exp_seq[n], resp_valid);
      resp_ready = exp_seq[n];
      tick();
      resp_ready = '0;
    end
    req_valid = '0;
    tick(); tick();
  endtask

  task automatic test_divide(input int idx, input logic [W-1:0] a, input logic [W-1:0] b,
                             input int exp_rd, input string name);
    logic [1:0] rdy;
    logic [1:0] want_oh;
    logic ok;
    int cyc;
    want_oh = (idx == 0) ? 2'b01 : 2'b10;
    issue(idx, a, b, rdy, ok);
    total++;
    if (!ok || rdy !== want_oh) begin
      bad++;
      $display("FAIL %s_accept: got %b want %b", name, rdy, want_oh);
    end
    total++;
    if (div_rs1 !== a || div_rs2 !== b) begin
      bad++;
      $display("FAIL %s_div_ops: got %0d/%0d want %0d/%0d", name, div_rs1, div_rs2, a, b);
    end
    wait_resp(cyc, ok);
    total++;
    if (!ok || cyc != LAT + 1) begin
      bad++;
      $display("FAIL %s_latency: got %0d cycles want %0d", name, cyc, LAT + 1);
    end
    total++;
    if (resp_valid !== want_oh || resp_err !== 1'b0 ||
        int'($signed(resp_rd)) < exp_rd - 1 || int'($signed(resp_rd)) > exp_rd + 1) begin
      bad++;
      $display("FAIL %s_result: got vld=%b rd=%0d err=%b want vld=%b rd=%0d(+-1) err=0",
               name, resp_valid, $signed(resp_rd), resp_err, want_oh, exp_rd);
    end
    $display("%s: rs1=%0d rs2=%0d rd=%0d err=%b after %0d cycles", name, a, b,
             $signed(resp_rd), resp_err, cyc);
    resp_ready = want_oh;
    tick();
    resp_ready = '0;
    total++;
    if (resp_valid !== 2'b00 || div_rs2 !== '0) begin
      bad++;
      $display("FAIL %s_release: got vld=%b div_rs2=%0d want 0/0", name, resp_valid, div_rs2);
    end
  endtask

  task automatic test_div_zero();
    logic [1:0] rdy;
    logic ok;
    int cyc;
    // Positive dividend on requester 0.
    issue(0, 12'd100, 12'd0, rdy, ok);
    wait_resp(cyc, ok);
    total++;
    if (!ok || cyc != 1 || resp_valid !== 2'b01 || resp_rd !== 12'd2047 || resp_err !== 1'b1) begin
      bad++;
      $display("FAIL dbz_pos: got cyc=%0d vld=%b rd=%0d err=%b want 1/01/2047/1",
               cyc, resp_valid, $signed(resp_rd), resp_err);
    end
    $display("dbz rs1=100: rd=%0d err=%b", $signed(resp_rd), resp_err);
    resp_ready = 2'b01;
    tick();
    resp_ready = '0;
    // Negative dividend on requester 1; requester 0's ready must be ignored.
    issue(1, 12'hFFB, 12'd0, rdy, ok);
    wait_resp(cyc, ok);
    resp_ready = 2'b01;
    tick(); tick();
    total++;
    if (!ok || cyc != 1 || resp_valid !== 2'b10 || resp_rd !== 12'h800 || resp_err !== 1'b1) begin
      bad++;
      $display("FAIL dbz_neg: got cyc=%0d vld=%b rd=%0d err=%b want 1/10/-2048/1",
               cyc, resp_valid, $signed(resp_rd), resp_err);
    end
    $display("dbz rs1=-5: rd=%0d err=%b", $signed(resp_rd), resp_err);
    resp_ready = 2'b10;
    tick();
    resp_ready = '0;
  endtask

  task automatic test_timeout();
    logic [1:0] rdy;
    logic ok;
    int cyc;
    stub_dead = 1'b1;
    issue(0, 12'd5, 12'd7, rdy, ok);
    wait_resp(cyc, ok);
    total++;
    if (!ok || cyc != LAT + TO || resp_valid !== 2'b01 || resp_rd !== '0 || resp_err !== 1'b1) begin
      bad++;
      $display("FAIL timeout: got cyc=%0d vld=%b rd=%0d err=%b want %0d/01/0/1",
               cyc, resp_valid, resp_rd, resp_err, LAT + TO);
    end
    $display("timeout: rd=%0d err=%b after %0d cycles", resp_rd, resp_err, cyc);
    resp_ready = 2'b01;
    tick();
    resp_ready = '0;
    stub_dead = 1'b0;
  endtask

  task automatic test_hold();
    logic [1:0] rdy;
    logic ok;
    int cyc;
    int unstable;
    issue(1, 12'd100, 12'd0, rdy, ok);
    wait_resp(cyc, ok);
    unstable = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (resp_valid !== 2'b10 || resp_rd !== 12'd2047 || resp_err !== 1'b1) unstable++;
    end
    total++;
    if (!ok || unstable != 0) begin
      bad++;
      $display("FAIL hold: got %0d unstable cycles vld=%b rd=%0d err=%b want 0",
               unstable, resp_valid, resp_rd, resp_err);
    end
    $display("hold: response stable for 5 withheld cycles");
    resp_ready = 2'b10;
    tick();
    resp_ready = '0;
  endtask

  task automatic test_reset_mid();
    logic [1:0] rdy;
    logic ok;
    int seen;
    issue(0, 12'd3, 12'd10, rdy, ok);
    tick(); tick(); tick(); tick(); tick();
    rst_n = 1'b0;
    tick();
    total++;
    if ({req_ready, resp_valid, resp_rd, resp_err, div_rs1, div_rs2} !== '0) begin
      bad++;
      $display("FAIL reset_mid_outputs: got rdy=%b vld=%b rd=%0d err=%b rs1=%0d rs2=%0d want all 0",
               req_ready, resp_valid, resp_rd, resp_err, div_rs1, div_rs2);
    end
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (resp_valid != '0) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++;
      $display("FAIL reset_mid_noresp: got %0d response cycles want 0", seen);
    end
    $display("reset mid-wait: operation discarded");
    // Pointer is reset too: with both requesting, requester 0 wins.
    req_rs2 = '0;
    req_valid = 2'b11;
    tick();
    req_valid = '0;
    total++;
    if (req_ready !== 2'b01) begin
      bad++;
      $display("FAIL reset_mid_ptr: got %b want 01", req_ready);
    end
    tick();
    resp_ready = 2'b01;
    tick();
    resp_ready = '0;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_divide(0, 12'd3, 12'd10, 614, "div_req0");
    test_divide(1, 12'd345, 12'd1860, 379, "div_req1");
    test_div_zero();
    test_timeout();
    test_hold();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
